router_port_drain: RTL and testbench
====================================

Name: router_port_drain

Overview:
- Downstream consumer for one output port of router_1x3. Drains the port FIFO using valid_out_x / read_enb_x / data_out_x.
- Reassembles each packet: header, payload, parity.
- Checks destination address and parity, and reports per-packet status.
- One instance per router output, with PORT_ID = 0, 1 or 2.

Parameters:
- PORT_ID, 0: expected header addr[1:0] for this port.
- TIMEOUT, 24: max consecutive cycles valid_out may stay low mid-packet before abort. Must be below the router's 30-cycle soft-reset window.
- CNT_W, 16: width of statistics counters.

Ports:
- clock  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- valid_out  in  1  router port FIFO not empty.
- data_out  in  8  router port FIFO read data; valid the cycle after read_enb is sampled high.
- hold  in  1  backpressure; while high, no new reads are issued.
- read_enb  out  1  FIFO read strobe to router.
- pkt_done  out  1  one-cycle pulse when a packet completes or aborts.
- pkt_ok  out  1  qualified by pkt_done; 1 = address and parity both good.
- parity_err  out  1  qualified by pkt_done.
- addr_err  out  1  qualified by pkt_done.
- trunc_err  out  1  qualified by pkt_done; packet aborted by timeout.
- pkt_len  out  6  payload length from the last header, held until the next header.
- in_packet  out  1  high from first read issued until pkt_done.
- pkt_count  out  CNT_W  packets completed (optional feature).
- err_count  out  CNT_W  packets with any error (optional feature).

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE; every output 0; parity accumulator, issue/receive counters and timeout counter all 0.
- read_enb is combinational: valid_out & ~hold & (state != DONE) & (issued < total).
  - total = 1 until the header is received, then pkt_len + 2.
  - read_enb is never high when valid_out is low.
- Read latency: exactly 1 cycle. A register rd_q (read_enb delayed by one cycle) marks data_out as valid to sample. Reads may be back-to-back.
- FSM states:
  - IDLE: on read_enb, go to HDR and set in_packet.
  - HDR: on rd_q, capture pkt_len = data_out[7:2], compare data_out[1:0] to PORT_ID, set acc = data_out. Go to PAY, or to PAR if pkt_len == 0.
  - PAY: each rd_q XORs data_out into acc and increments rcvd. After pkt_len bytes, go to PAR.
  - PAR: on rd_q, parity_err = (acc != data_out). Go to DONE.
  - DONE: one cycle. Pulse pkt_done with the flags, clear in_packet and the counters, return to IDLE. No read is issued in DONE.
- Byte 2 read issue: a read may already be issued in the same cycle the header byte is sampled, because total is still 1 plus the in-flight read. total is recomputed from that cycle on, and no read beyond pkt_len+2 total is ever issued.
- Timeout:
  - In HDR/PAY/PAR, a counter increments on each cycle with valid_out=0 and no rd_q. It clears on any rd_q.
  - When it reaches TIMEOUT: go to DONE with trunc_err=1, pkt_ok=0. parity_err and addr_err are reported as captured so far.
  - hold=1 does not count toward timeout when valid_out=1.
- Address error: the packet is still fully drained. addr_err is reported at completion.
- pkt_ok = ~parity_err & ~addr_err & ~trunc_err.
- If resetn asserts mid-packet, everything clears immediately. The next valid_out is treated as a header.

Optional Feature:
- ROUTER_DRAIN_STATS_EN
  - Defined: pkt_count increments on every pkt_done. err_count increments on pkt_done with pkt_ok=0. Both saturate at all-ones and clear on reset.
  - Undefined: pkt_count and err_count are tied to 0 and no counter flops are synthesized.

Test Plan:
- Good packet: PORT_ID=0; router fed len=8, addr=00, correct parity; hold=0 → 10 read_enb cycles; pkt_done with pkt_ok=1, pkt_len=8; pkt_count=1.
- Corrupt parity: len=5, addr=10 into PORT_ID=2 instance; parity byte XOR 0x01 → pkt_done with parity_err=1, pkt_ok=0; err_count=1.
- Wrong port: PORT_ID=1 instance given header 0x28 (len=10, addr=00) → all 12 bytes drained; addr_err=1, parity_err=0.
- Backpressure: len=16; hold=1 for 6 cycles mid-payload → read_enb=0 during hold; no trunc_err; pkt_ok=1; 18 total reads.
- Timeout: len=12; valid_out forced low after 4 payload bytes → pkt_done exactly TIMEOUT (24) cycles later with trunc_err=1; in_packet=0; next header accepted.
- Zero length and reset: len=0 → exactly 2 reads, pkt_ok=1. Then resetn low mid-packet → all outputs 0 asynchronously; a following len=3 packet completes with pkt_ok=1.

Source files
------------

// File: rtl/router_port_drain.sv
// router_port_drain: consumer for one router_1x3 output port; reassembles header/payload/parity
// and reports per-packet status. Saturating packet/error counters exist only with ROUTER_DRAIN_STATS_EN.
//
// state | meaning
// IDLE  | no packet; the first read issued starts one
// HDR   | header byte in flight; capture length and address
// PAY   | payload bytes arriving; XOR into parity accumulator
// PAR   | parity byte in flight; compare with accumulator
// DONE  | one-cycle status pulse; per-packet state cleared
module router_port_drain #(
    parameter int          PORT_ID = 0,
    parameter int unsigned TIMEOUT = 24,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             valid_out,
    input  logic [7:0]       data_out,
    input  logic             hold,
    output logic             read_enb,
    output logic             pkt_done,
    output logic             pkt_ok,
    output logic             parity_err,
    output logic             addr_err,
    output logic             trunc_err,
    output logic [5:0]       pkt_len,
    output logic             in_packet,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [2:0] {IDLE, HDR, PAY, PAR, DONE} state_t;

    localparam int TO_W = $clog2(TIMEOUT + 1);

    state_t          state;
    state_t          state_next;
    logic            rd_q;
    logic [6:0]      issued;
    logic [6:0]      total;
    logic [5:0]      rcvd;
    logic [7:0]      acc;
    logic [TO_W-1:0] to_cnt;
    logic [5:0]      len_q;
    logic            addr_bad;
    logic            par_bad;
    logic            trunc_q;
    logic            active;
    logic            starve;
    logic            to_hit;
    logic            hdr_take;

    assign active   = (state == HDR) || (state == PAY) || (state == PAR);
    assign starve   = active && !valid_out && !rd_q;
    assign to_hit   = starve && (to_cnt == TO_W'(TIMEOUT - 1));
    assign hdr_take = (state == HDR) && rd_q;

    // The header length is used in the very cycle it arrives so byte 2 can be read back-to-back.
    always_comb begin
        total = 7'd1;
        if (hdr_take) begin
            total = {1'b0, data_out[7:2]} + 7'd2;
        end else if ((state == PAY) || (state == PAR)) begin
            total = {1'b0, len_q} + 7'd2;
        end
    end

    assign read_enb = valid_out && !hold && (state != DONE) && (issued < total);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (read_enb) state_next = HDR;
            end
            HDR: begin
                if (rd_q) begin
                    state_next = (data_out[7:2] == 6'd0) ? PAR : PAY;
                end else if (to_hit) begin
                    state_next = DONE;
                end
            end
            PAY: begin
                if (rd_q && ((rcvd + 6'd1) == len_q)) begin
                    state_next = PAR;
                end else if (to_hit) begin
                    state_next = DONE;
                end
            end
            PAR: begin
                if (rd_q || to_hit) state_next = DONE;
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rd_q     <= 1'b0;
            issued   <= '0;
            rcvd     <= '0;
            acc      <= '0;
            to_cnt   <= '0;
            len_q    <= '0;
            addr_bad <= 1'b0;
            par_bad  <= 1'b0;
            trunc_q  <= 1'b0;
        end else begin
            rd_q <= read_enb;
            if (state == DONE) begin
                issued   <= '0;
                rcvd     <= '0;
                acc      <= '0;
                to_cnt   <= '0;
                addr_bad <= 1'b0;
                par_bad  <= 1'b0;
                trunc_q  <= 1'b0;
            end else begin
                if (read_enb) issued <= issued + 7'd1;

                if (rd_q) begin
                    to_cnt <= '0;
                end else if (starve) begin
                    to_cnt <= to_cnt + TO_W'(1);
                end

                if (hdr_take) begin
                    len_q    <= data_out[7:2];
                    addr_bad <= (data_out[1:0] != 2'(PORT_ID));
                    acc      <= data_out;
                end

                if ((state == PAY) && rd_q) begin
                    acc  <= acc ^ data_out;
                    rcvd <= rcvd + 6'd1;
                end

                if ((state == PAR) && rd_q) par_bad <= (acc != data_out);

                if (to_hit) trunc_q <= 1'b1;
            end
        end
    end

    // Status flags are only meaningful alongside pkt_done, so they read 0 otherwise.
    assign pkt_done   = (state == DONE);
    assign addr_err   = pkt_done && addr_bad;
    assign parity_err = pkt_done && par_bad;
    assign trunc_err  = pkt_done && trunc_q;
    assign pkt_ok     = pkt_done && !addr_bad && !par_bad && !trunc_q;
    assign pkt_len    = len_q;
    assign in_packet  = active;

`ifdef ROUTER_DRAIN_STATS_EN
    logic [CNT_W-1:0] pkt_cnt_q;
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pkt_cnt_q <= '0;
            err_cnt_q <= '0;
        end else if (pkt_done) begin
            if (pkt_cnt_q != '1) pkt_cnt_q <= pkt_cnt_q + CNT_W'(1);
            if (!pkt_ok && (err_cnt_q != '1)) err_cnt_q <= err_cnt_q + CNT_W'(1);
        end
    end

    assign pkt_count = pkt_cnt_q;
    assign err_count = err_cnt_q;
`else
    assign pkt_count = '0;
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_router_port_drain.sv
// tb_router_port_drain: one router port stream feeds three drains (PORT_ID 0..2); every packet is
// checked against a packet-level model of reads, status flags, timeout latency and statistics.
module tb_router_port_drain;

    localparam int TIMEOUT = 24;
    localparam int CNT_W   = 16;

    logic       clock     = 1'b0;
    logic       resetn    = 1'b0;
    logic       valid_out = 1'b0;
    logic       hold      = 1'b0;
    logic [7:0] data_out  = 8'h00;

    logic             read_enb   [3];
    logic             pkt_done   [3];
    logic             pkt_ok     [3];
    logic             parity_err [3];
    logic             addr_err   [3];
    logic             trunc_err  [3];
    logic [5:0]       pkt_len    [3];
    logic             in_packet  [3];
    logic [CNT_W-1:0] pkt_count  [3];
    logic [CNT_W-1:0] err_count  [3];

    always #5 clock = ~clock;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        router_port_drain #(.PORT_ID(g), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_dut (
            .clock      (clock),
            .resetn     (resetn),
            .valid_out  (valid_out),
            .data_out   (data_out),
            .hold       (hold),
            .read_enb   (read_enb[g]),
            .pkt_done   (pkt_done[g]),
            .pkt_ok     (pkt_ok[g]),
            .parity_err (parity_err[g]),
            .addr_err   (addr_err[g]),
            .trunc_err  (trunc_err[g]),
            .pkt_len    (pkt_len[g]),
            .in_packet  (in_packet[g]),
            .pkt_count  (pkt_count[g]),
            .err_count  (err_count[g])
        );
    end

    int         checks = 0;
    int         errors = 0;
    logic [7:0] fifo[$];
    int         exp_pkts[3];
    int         exp_errs[3];
    int         last_len = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_stat(input int v);
`ifdef ROUTER_DRAIN_STATS_EN
        return 32'(v);
`else
        return (v < 0) ? 32'd1 : 32'd0;
`endif
    endfunction

    // Outputs between packets: no strobe, no pulse, length held, statistics per model.
    task automatic check_quiet(input string when, input bit all_zero);
        for (int g = 0; g < 3; g++) begin
            chk($sformatf("%s p%0d read_enb", when, g), 32'(read_enb[g]), 0);
            chk($sformatf("%s p%0d pkt_done", when, g), 32'(pkt_done[g]), 0);
            chk($sformatf("%s p%0d in_packet", when, g), 32'(in_packet[g]), 0);
            chk($sformatf("%s p%0d pkt_len", when, g), 32'(pkt_len[g]), 32'(last_len));
            chk($sformatf("%s p%0d pkt_count", when, g), 32'(pkt_count[g]), exp_stat(exp_pkts[g]));
            chk($sformatf("%s p%0d err_count", when, g), 32'(err_count[g]), exp_stat(exp_errs[g]));
            if (all_zero) begin
                chk($sformatf("%s p%0d pkt_ok", when, g), 32'(pkt_ok[g]), 0);
                chk($sformatf("%s p%0d parity_err", when, g), 32'(parity_err[g]), 0);
                chk($sformatf("%s p%0d addr_err", when, g), 32'(addr_err[g]), 0);
                chk($sformatf("%s p%0d trunc_err", when, g), 32'(trunc_err[g]), 0);
            end
        end
    endtask

    // keep < 0: whole packet delivered; keep >= 0: only header plus keep payload bytes ever appear.
    // abort_at >= 0: resetn is pulsed at that cycle instead of waiting for completion.
    task automatic run_packet(input int len, input int addr, input bit corrupt, input int keep,
                              input int hold_at, input int hold_len,
                              input int starve_at, input int starve_len, input int abort_at);
        logic [7:0] hdr;
        logic [7:0] par;
        logic [7:0] b;
        logic       rd;
        bit         trunc;
        bit         done;
        bit         inp_prev;
        bit         a_err;
        bit         p_err;
        bit         ok;
        int         reads;
        int         viol;
        int         since_rd;
        int         cyc;

        check_quiet("pre", 1'b0);
        trunc = (keep >= 0);
        hdr   = {len[5:0], addr[1:0]};
        par   = hdr;
        fifo.push_back(hdr);
        for (int i = 0; i < len; i++) begin
            b = 8'($urandom);
            par ^= b;
            if (!trunc || i < keep) fifo.push_back(b);
        end
        if (corrupt) par ^= 8'h01;
        if (!trunc) fifo.push_back(par);

        valid_out = 1'b1;
        reads = 0; viol = 0; since_rd = -1; done = 0; inp_prev = 0;
        for (cyc = 0; cyc < 600 && !done; cyc++) begin
            @(negedge clock);
            if (read_enb[0] !== read_enb[1] || read_enb[0] !== read_enb[2]) viol++;
            rd = read_enb[0];
            if (since_rd >= 0) since_rd++;
            if (rd === 1'b1) begin
                reads++;
                if (hold || !valid_out) viol++;
                since_rd = 0;
            end
            if (abort_at >= 0 && cyc == abort_at) begin
                #2;
                resetn = 1'b0;
                valid_out = 1'b0;
                hold = 1'b0;
                fifo.delete();
                for (int g = 0; g < 3; g++) begin
                    exp_pkts[g] = 0;
                    exp_errs[g] = 0;
                end
                last_len = 0;
                #1;
                check_quiet("async_reset", 1'b1);
                repeat (2) @(posedge clock);
                #1;
                resetn = 1'b1;
                return;
            end
            if (pkt_done[0] === 1'b1) begin
                done = 1;
            end else begin
                inp_prev = (in_packet[0] === 1'b1);
                @(posedge clock);
                #1;
                if (rd === 1'b1) begin
                    if (fifo.size() > 0) data_out = fifo.pop_front();
                    else begin
                        viol++;
                        data_out = 8'($urandom);
                    end
                end else begin
                    data_out = 8'($urandom);
                end
                hold = (cyc + 1 >= hold_at) && (cyc + 1 < hold_at + hold_len);
                valid_out = (fifo.size() > 0) && !((cyc + 1 >= starve_at) && (cyc + 1 < starve_at + starve_len));
            end
        end

        chk("pkt_done_seen", 32'(done), 1);
        chk("reads", 32'(reads), trunc ? 32'(1 + keep) : 32'(len + 2));
        chk("strobe_violations", 32'(viol), 0);
        chk("in_packet_before_done", 32'(inp_prev), 1);
        // Last strobe, one cycle of read latency, TIMEOUT idle cycles, then the pulse.
        if (trunc) chk("timeout_latency", 32'(since_rd), 32'(TIMEOUT + 2));
        last_len = len;
        if (done) begin
            for (int g = 0; g < 3; g++) begin
                a_err = (addr != g);
                p_err = !trunc && corrupt;
                ok    = !a_err && !p_err && !trunc;
                chk($sformatf("p%0d pkt_done", g), 32'(pkt_done[g]), 1);
                chk($sformatf("p%0d pkt_ok", g), 32'(pkt_ok[g]), 32'(ok));
                chk($sformatf("p%0d parity_err", g), 32'(parity_err[g]), 32'(p_err));
                chk($sformatf("p%0d addr_err", g), 32'(addr_err[g]), 32'(a_err));
                chk($sformatf("p%0d trunc_err", g), 32'(trunc_err[g]), 32'(trunc));
                chk($sformatf("p%0d pkt_len", g), 32'(pkt_len[g]), 32'(len));
                chk($sformatf("p%0d in_packet_at_done", g), 32'(in_packet[g]), 0);
                exp_pkts[g]++;
                if (!ok) exp_errs[g]++;
            end
        end
        @(posedge clock);
        #1;
        valid_out = 1'b0;
        hold = 1'b0;
        fifo.delete();
        data_out = 8'($urandom);
        @(negedge clock);
        check_quiet("post", 1'b0);
        @(posedge clock);
        #1;
    endtask

    initial begin
        int len;
        int keep;
        for (int g = 0; g < 3; g++) begin
            exp_pkts[g] = 0;
            exp_errs[g] = 0;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_quiet("reset", 1'b1);
        resetn = 1'b1;
        @(posedge clock);
        #1;

        run_packet(8, 0, 1'b0, -1, -1, 0, -1, 0, -1);   // good packet for port 0
        run_packet(5, 2, 1'b1, -1, -1, 0, -1, 0, -1);   // parity byte XOR 0x01
        run_packet(10, 0, 1'b0, -1, -1, 0, -1, 0, -1);  // header 0x28: wrong port for 1 and 2
        run_packet(16, 1, 1'b0, -1, 6, 6, -1, 0, -1);   // 6-cycle hold mid-payload
        run_packet(16, 2, 1'b0, -1, 5, 40, -1, 0, -1);  // hold far longer than TIMEOUT
        run_packet(12, 0, 1'b0, 4, -1, 0, -1, 0, -1);   // valid_out gone after 4 payload bytes
        run_packet(3, 1, 1'b0, -1, -1, 0, 3, 20, -1);   // starve gap shorter than TIMEOUT
        run_packet(0, 0, 1'b0, -1, -1, 0, -1, 0, -1);   // zero length
        run_packet(0, 1, 1'b0, 0, -1, 0, -1, 0, -1);    // zero length, parity never arrives
        run_packet(63, 3, 1'b0, -1, -1, 0, -1, 0, -1);  // maximum length
        run_packet(20, 1, 1'b0, -1, -1, 0, -1, 0, 6);   // resetn mid-packet
        run_packet(3, 0, 1'b0, -1, -1, 0, -1, 0, -1);   // first packet after reset

        repeat (25) begin
            len  = $urandom_range(0, 63);
            keep = ($urandom_range(0, 4) == 0) ? $urandom_range(0, len) : -1;
            run_packet(len, $urandom_range(0, 3), ($urandom_range(0, 3) == 0), keep,
                       $urandom_range(0, 20), $urandom_range(0, 30),
                       $urandom_range(0, 30), $urandom_range(0, 15), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
